// File: rtl/sysbus_pkg.sv
// Shared Sysbus arbiter definitions: FSM state encoding, tag layout and
// the tag-building helper used by sysbus_tag_arbiter.
package sysbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WAIT,
        RESP
    } arb_state_t;

    // Native Sysbus tag width; the tag layout below is defined against it.
    localparam int SYSBUS_TAG_WIDTH = 13;
    localparam int TAG_WRITE_BIT    = SYSBUS_TAG_WIDTH - 1;
    localparam int TAG_OWNER_BIT    = 0;

    // Tag = write flag in the top bit, owner id in bit 0, everything else zero.
    function automatic logic [SYSBUS_TAG_WIDTH-1:0] make_tag(input logic write, input logic owner);
        logic [SYSBUS_TAG_WIDTH-1:0] tag;
        tag                = '0;
        tag[TAG_WRITE_BIT] = write;
        tag[TAG_OWNER_BIT] = owner;
        return tag;
    endfunction

endpackage

// File: rtl/sysbus_tag_arbiter_rr.sv
// Two-way round-robin picker. The pointer only matters when both ports
// request together; it then names the winner and flips to the other port.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       take,
    output logic       pick
);

    logic rr_ptr;

    // Winner selection: pointer breaks ties, a lone requester always wins.
    always_comb begin
        unique case (valid)
            2'b11:   pick = rr_ptr;
            2'b10:   pick = 1'b1;
            default: pick = 1'b0;
        endcase
    end

    // Pointer register: moves past the winner of a contested arbitration.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (take && (&valid))
            rr_ptr <= ~rr_ptr;
    end

endmodule

// File: rtl/sysbus_tag_arbiter.sv
// Sysbus master-port sharer for instruction fetch (port 0) and data cache
// (port 1). Arbitrates whole line transactions, drives the request phase,
// tags requests with the owner and routes read beats back by tag.
// Optional build macro: SYSBUS_ARB_TIMEOUT_EN adds a 10-bit response watchdog.
module sysbus_tag_arbiter
    import sysbus_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int BEATS      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            rq_valid,
    input  logic [1:0]            rq_write,
    input  logic [DATA_WIDTH-1:0] rq_addr0,
    input  logic [DATA_WIDTH-1:0] rq_addr1,
    input  logic [DATA_WIDTH-1:0] rq_wdata0,
    input  logic [DATA_WIDTH-1:0] rq_wdata1,
    output logic [1:0]            rq_grant,
    output logic [1:0]            rq_wnext,
    output logic [1:0]            rs_valid,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic                  rs_last,
    output logic                  tag_err,
    output logic [DATA_WIDTH-1:0] req,
    output logic [TAG_WIDTH-1:0]  reqtag,
    output logic                  reqcyc,
    input  logic                  reqack,
    input  logic [DATA_WIDTH-1:0] resp,
    input  logic [TAG_WIDTH-1:0]  resptag,
    input  logic                  respcyc,
    output logic                  respack
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t            state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  owner;
    logic                  wr;
    logic [DATA_WIDTH-1:0] addr;
    logic                  take;
    logic                  pick;
    logic                  resp_match;
    logic                  good_beat;
    logic [TAG_WIDTH-1:0]  cur_tag;
    logic [TAG_WIDTH-1:0]  read_tag;

`ifdef SYSBUS_ARB_TIMEOUT_EN
    localparam int WDOG_WIDTH = 10;
    localparam logic [WDOG_WIDTH-1:0] WDOG_MAX = '1;
    logic [WDOG_WIDTH-1:0] wd;
`endif

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .valid (rq_valid),
        .take  (take),
        .pick  (pick)
    );

    // The tag layout assumes TAG_WIDTH equals the native Sysbus tag width.
    assign cur_tag    = TAG_WIDTH'(make_tag(wr, owner));
    assign read_tag   = TAG_WIDTH'(make_tag(1'b0, owner));
    assign resp_match = (resptag == read_tag);
    assign good_beat  = respcyc && resp_match && ((state == WAIT) || (state == RESP));

    // Next-state and all bus/requester outputs; read beats pass through combinationally.
    // NOTE: every output and next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        take     = 1'b0;
        reqcyc   = 1'b0;
        req      = '0;
        reqtag   = '0;
        rq_grant = '0;
        rq_wnext = '0;
        rs_valid = '0;
        rs_data  = '0;
        rs_last  = 1'b0;
        respack  = respcyc;
        // Any beat we cannot route is still acked so the bus never stalls on it.
        tag_err  = respcyc && !good_beat;

        if (good_beat) begin
            rs_valid[owner] = 1'b1;
            rs_data         = resp;
            rs_last         = (cnt == LAST_BEAT);
        end

        unique case (state)
            IDLE: begin
                if (|rq_valid) begin
                    take    = 1'b1;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                reqcyc = 1'b1;
                req    = addr;
                reqtag = cur_tag;
                if (reqack) begin
                    rq_grant[owner] = 1'b1;
                    cnt_n           = '0;
                    state_n         = wr ? WDATA : WAIT;
                end
            end
            WDATA: begin
                reqcyc = 1'b1;
                req    = owner ? rq_wdata1 : rq_wdata0;
                reqtag = cur_tag;
                if (reqack) begin
                    rq_wnext[owner] = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            WAIT, RESP: begin
                if (good_beat) begin
                    if (cnt == LAST_BEAT) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = cnt + 1'b1;
                        state_n = RESP;
                    end
                end
`ifdef SYSBUS_ARB_TIMEOUT_EN
                else if (wd == WDOG_MAX) begin
                    // Abandon the line: owner sees no rs_last and must re-request.
                    tag_err = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, beat counter and the latched transaction (owner, direction, address).
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= 1'b0;
            wr    <= 1'b0;
            addr  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (take) begin
                owner <= pick;
                wr    <= pick ? rq_write[1] : rq_write[0];
                addr  <= pick ? rq_addr1 : rq_addr0;
            end
        end
    end

`ifdef SYSBUS_ARB_TIMEOUT_EN
    // Watchdog: counts idle response cycles, restarts on every routed beat or exit.
    always_ff @(posedge clk) begin
        if (reset)
            wd <= '0;
        else if (((state == WAIT) || (state == RESP)) && !good_beat && (state_n != IDLE))
            wd <= wd + 1'b1;
        else
            wd <= '0;
    end
`endif

endmodule

// File: tb/tb_sysbus_tag_arbiter.sv
// Directed-plus-random bench for sysbus_tag_arbiter. A small transaction-level
// model (round-robin pointer, per-port pending requests, tag formula) supplies
// every expected value; all checks are immediate assertions.
module tb_sysbus_tag_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    rq_valid, rq_write;
    logic [DW-1:0] rq_addr0, rq_addr1, rq_wdata0, rq_wdata1;
    logic [1:0]    rq_grant, rq_wnext, rs_valid;
    logic [DW-1:0] rs_data;
    logic          rs_last, tag_err;
    logic [DW-1:0] req;
    logic [TW-1:0] reqtag;
    logic          reqcyc, reqack;
    logic [DW-1:0] resp;
    logic [TW-1:0] resptag;
    logic          respcyc, respack;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int            rr_m;
    bit            req_on [2];
    bit            req_wr [2];
    logic [DW-1:0] req_addr [2];
    logic [DW-1:0] wbeat [2][BEATS];

    sysbus_tag_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .rq_valid(rq_valid), .rq_write(rq_write),
        .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
        .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
        .rq_grant(rq_grant), .rq_wnext(rq_wnext),
        .rs_valid(rs_valid), .rs_data(rs_data), .rs_last(rs_last), .tag_err(tag_err),
        .req(req), .reqtag(reqtag), .reqcyc(reqcyc), .reqack(reqack),
        .resp(resp), .resptag(resptag), .respcyc(respcyc), .respack(respack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Tag formula: write flag at bit TW-1, owner at bit 0.
    function automatic logic [63:0] exp_tag(input bit w, input int o);
        logic [63:0] t;
        t         = '0;
        t[TW-1]   = w;
        t[0]      = (o == 1);
        return t;
    endfunction

    // Arbitration rule: tie goes to the pointer which then flips; lone requester wins.
    task automatic arbitrate(output int w);
        if (rq_valid == 2'b11) begin
            w    = rr_m;
            rr_m = 1 - rr_m;
        end else begin
            w = rq_valid[1] ? 1 : 0;
        end
    endtask

    task automatic set_port(input int p, input logic [DW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin rq_addr0 = a; rq_wdata0 = d; end
        else        begin rq_addr1 = a; rq_wdata1 = d; end
    endtask

    task automatic post(input int p, input bit w);
        req_on[p]   = 1'b1;
        req_wr[p]   = w;
        req_addr[p] = {$urandom, $urandom};
        for (int k = 0; k < BEATS; k++) wbeat[p][k] = {$urandom, $urandom};
        rq_valid[p] = 1'b1;
        rq_write[p] = w;
        set_port(p, req_addr[p], wbeat[p][0]);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_reqcyc"},   reqcyc,   0);
        check({tag, "_req"},      req,      0);
        check({tag, "_reqtag"},   reqtag,   0);
        check({tag, "_grant"},    rq_grant, 0);
        check({tag, "_wnext"},    rq_wnext, 0);
        check({tag, "_rs_valid"}, rs_valid, 0);
        check({tag, "_rs_last"},  rs_last,  0);
        check({tag, "_tag_err"},  tag_err,  0);
        check({tag, "_respack"},  respack,  0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rq_valid = '0;
        reqack   = 1'b0;
        respcyc  = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        rr_m    = 0;
        req_on  = '{default: 1'b0};
    endtask

    // Called at the negedge where the DUT sits in ADDR for owner o. Returns at the
    // negedge where the DUT is back in IDLE (or right after an abort reset).
    task automatic serve(input int o, input int ack_dly, input int gap_max,
                         input bit fixed_data, input bit bad_tags, input int abort_at);
        logic [63:0] t;
        logic [DW-1:0] d;
        int gap;
        t = exp_tag(req_wr[o], o);
        for (int i = 0; i < ack_dly; i++) begin
            #1;
            check("addr_reqcyc", reqcyc, 1);
            check("addr_req_stable", req, req_addr[o]);
            check("addr_tag_stable", reqtag, t);
            check("addr_no_grant", rq_grant, 0);
            @(negedge clk);
        end
        reqack = 1'b1;
        #1;
        check("grant", rq_grant, 64'(2'b01 << o));
        check("addr_req", req, req_addr[o]);
        check("reqtag", reqtag, t);
        rq_valid[o] = 1'b0;
        req_on[o]   = 1'b0;
        @(negedge clk);
        reqack = 1'b0;
        if (req_wr[o]) begin
            for (int k = 0; k < BEATS; k++) begin
                set_port(o, req_addr[o], wbeat[o][k]);
                for (int i = 0; i < ack_dly; i++) begin
                    #1;
                    check("wr_reqcyc", reqcyc, 1);
                    check("wr_req_stable", req, wbeat[o][k]);
                    check("wr_tag_stable", reqtag, t);
                    check("wr_no_wnext", rq_wnext, 0);
                    @(negedge clk);
                end
                reqack = 1'b1;
                #1;
                check("wnext", rq_wnext, 64'(2'b01 << o));
                check("wr_req", req, wbeat[o][k]);
                @(negedge clk);
                reqack = 1'b0;
            end
        end else begin
            for (int k = 0; k < BEATS; k++) begin
                if (k == abort_at) begin
                    reset   = 1'b1;
                    respcyc = 1'b0;
                    @(negedge clk);
                    #1;
                    check_quiet("rst_mid_resp");
                    reset = 1'b0;
                    rr_m  = 0;
                    return;
                end
                if (bad_tags && (k == 0 || k == 3)) begin
                    respcyc = 1'b1;
                    resp    = {$urandom, $urandom};
                    resptag = TW'(exp_tag(1'b0, 1 - o));
                    #1;
                    check("bad_owner_respack", respack, 1);
                    check("bad_owner_tag_err", tag_err, 1);
                    check("bad_owner_rs_valid", rs_valid, 0);
                    @(negedge clk);
                    resptag = TW'(exp_tag(1'b1, o));
                    #1;
                    check("bad_wbit_respack", respack, 1);
                    check("bad_wbit_tag_err", tag_err, 1);
                    check("bad_wbit_rs_valid", rs_valid, 0);
                    check("bad_wbit_reqcyc", reqcyc, 0);
                    @(negedge clk);
                    respcyc = 1'b0;
                end
                gap = $urandom_range(0, gap_max);
                for (int i = 0; i < gap; i++) begin
                    #1;
                    check("gap_rs_valid", rs_valid, 0);
                    check("gap_tag_err", tag_err, 0);
                    @(negedge clk);
                end
                d       = fixed_data ? DW'(64'h10 + 64'(k)) : {$urandom, $urandom};
                respcyc = 1'b1;
                resptag = TW'(t);
                resp    = d;
                #1;
                check("rs_valid", rs_valid, 64'(2'b01 << o));
                check("rs_data", rs_data, d);
                check("rs_last", rs_last, (k == BEATS - 1) ? 1 : 0);
                check("respack", respack, 1);
                check("rd_tag_err", tag_err, 0);
                @(negedge clk);
                respcyc = 1'b0;
            end
        end
        #1;
        check("idle_after_txn", reqcyc, 0);
    endtask

    int w;
    bit flag;

    initial begin
        reset = 1'b1;
        rq_valid = '0; rq_write = '0;
        rq_addr0 = '0; rq_addr1 = '0; rq_wdata0 = '0; rq_wdata1 = '0;
        reqack = 1'b0; respcyc = 1'b0; resp = '0; resptag = '0;
        rr_m = 0;
        req_on = '{default: 1'b0};
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset_rs_data", rs_data, 0);
        @(negedge clk);
        reset = 1'b0;

        // Lone read on port 0, immediate ack, data 0x10..0x17.
        post(0, 1'b0);
        arbitrate(w);
        @(negedge clk);
        serve(w, 0, 0, 1'b1, 1'b0, -1);

        // Simultaneous reads after reset: port 0 then port 1.
        do_reset();
        post(0, 1'b0);
        post(1, 1'b0);
        arbitrate(w);
        @(negedge clk);
        serve(w, 0, 1, 1'b0, 1'b0, -1);
        arbitrate(w);
        @(negedge clk);
        serve(w, 1, 1, 1'b0, 1'b0, -1);

        // Write on port 1 with three-cycle ack delay on every beat.
        post(1, 1'b1);
        arbitrate(w);
        @(negedge clk);
        serve(w, 3, 0, 1'b0, 1'b0, -1);

        // Misrouted response beats in WAIT and mid-RESP on a port-0 read.
        post(0, 1'b0);
        arbitrate(w);
        @(negedge clk);
        serve(w, 0, 1, 1'b0, 1'b1, -1);

        // Stray beat while idle.
        respcyc = 1'b1;
        resptag = '0;
        resp    = {$urandom, $urandom};
        #1;
        check("idle_beat_tag_err", tag_err, 1);
        check("idle_beat_respack", respack, 1);
        check("idle_beat_rs_valid", rs_valid, 0);
        @(negedge clk);
        respcyc = 1'b0;

        // Reset mid-RESP at beat 4, then a fresh port-1 read.
        post(0, 1'b0);
        arbitrate(w);
        @(negedge clk);
        serve(w, 0, 0, 1'b0, 1'b0, 4);
        post(1, 1'b0);
        arbitrate(w);
        @(negedge clk);
        serve(w, 0, 0, 1'b0, 1'b0, -1);

        // Random mix of reads/writes, overlapping requests and ack delays.
        for (int it = 0; it < 12; it++) begin
            for (int p = 0; p < 2; p++)
                if (!req_on[p] && ($urandom_range(0, 1) == 1)) post(p, $urandom_range(0, 1) == 1);
            if (rq_valid == 2'b00) post($urandom_range(0, 1), $urandom_range(0, 1) == 1);
            arbitrate(w);
            @(negedge clk);
            serve(w, $urandom_range(0, 2), 2, 1'b0, 1'b0, -1);
        end
        if (rq_valid != 2'b00) begin
            arbitrate(w);
            @(negedge clk);
            serve(w, 0, 0, 1'b0, 1'b0, -1);
        end

`ifdef SYSBUS_ARB_TIMEOUT_EN
        // Silent bus after a read: watchdog fires on the 1024th WAIT cycle.
        post(0, 1'b0);
        arbitrate(w);
        @(negedge clk);
        reqack = 1'b1;
        rq_valid[0] = 1'b0;
        req_on[0]   = 1'b0;
        @(negedge clk);
        reqack = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            #1;
            if (tag_err) flag = 1'b1;
            @(negedge clk);
        end
        check("wdog_early", flag, 0);
        #1;
        check("wdog_tag_err", tag_err, 1);
        check("wdog_no_last", rs_last, 0);
        @(negedge clk);
        #1;
        check("wdog_idle", reqcyc, 0);
        post(1, 1'b0);
        arbitrate(w);
        @(negedge clk);
        serve(w, 0, 0, 1'b0, 1'b0, -1);
`else
        flag = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sysbus_tag_arbiter.md
# sysbus_tag_arbiter

Shares the single Sysbus master port between two requesters: port 0 (instruction fetch) and port 1 (data cache). It round-robin arbitrates whole transactions and drives the request phase (address beat plus write-data beats). It tags each request with the owner id and routes read-response beats back to the owner by tag. One transaction is in flight at a time; the block sits between the L1 caches and the Sysbus Top modport.

## Interface
Parameters:
- DATA_WIDTH, 64, bus beat width and address width
- TAG_WIDTH, 13, Sysbus tag width
- BEATS, 8, data beats per line (64-byte line)

Ports (clk and reset first; one clock, reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rq_valid[1:0]  in  2  per-port transaction request, held until rq_grant
- rq_write[1:0]  in  2  1 = write line, 0 = read line
- rq_addr0, rq_addr1  in  DATA_WIDTH  line address
- rq_wdata0, rq_wdata1  in  DATA_WIDTH  current write beat
- rq_grant[1:0]  out  2  one-cycle pulse: address beat accepted by bus
- rq_wnext[1:0]  out  2  one-cycle pulse: write beat accepted, present next
- rs_valid[1:0]  out  2  read beat valid for port
- rs_data  out  DATA_WIDTH  read beat data, shared by both ports
- rs_last  out  1  final beat of line
- tag_err  out  1  one-cycle pulse on unexpected resptag
- req, reqtag, reqcyc, reqack, resp, resptag, respcyc, respack  Sysbus signals (out, out, out, in, in, in, in, out)

## Operation
- Tag format: reqtag[TAG_WIDTH-1] = write bit; reqtag[0] = owner id; all other bits 0.
- FSM states: IDLE, ADDR, WDATA, WAIT, RESP.
- IDLE:
  - Any rq_valid → latch owner, write and addr → ADDR.
  - Both ports valid → the port selected by rr_ptr wins. rr_ptr then points at the other port. Reset value of rr_ptr is 0.
- ADDR: reqcyc=1, req=addr, reqtag per format. On reqack: pulse rq_grant[owner]. Write → WDATA with beat count 0; read → WAIT.
- WDATA:
  - reqcyc=1, req=rq_wdata[owner]. Each reqack pulses rq_wnext[owner] and increments the count.
  - The ack of beat BEATS-1 → IDLE. Writes get no response.
- WAIT: respcyc with resptag matching {0,…,owner} → RESP path. The first beat is consumed in the same cycle.
- RESP:
  - respack = respcyc (combinational). Each beat gives rs_valid[owner]=1 and rs_data=resp.
  - rs_last=1 on beat BEATS-1, then → IDLE.
  - Requesters must accept beats unconditionally.
- Mismatched resptag (wrong owner, write bit set, or any beat outside WAIT/RESP): still acked, data discarded, tag_err pulsed, state unchanged.
- Beat counter: log2(BEATS) bits, wraps to 0 on exit.
- Reset at any point:
  - State → IDLE; all outputs 0; counters 0; rr_ptr 0.
  - In-flight transaction abandoned; the owner must re-request.

## Timing
- Grant latency: rq_valid in IDLE at cycle N → reqcyc=1 at N+1. Arbitration is registered.
- rq_grant pulses in the reqack cycle. Back-to-back transactions: IDLE lasts at least 1 cycle between them.
- req and reqtag stay stable while reqcyc=1 and reqack=0.
- rs_valid and rs_data are combinational from respcyc/resp; zero added latency.
- Minimum read: 1 (IDLE) + 1 (ADDR with immediate ack) + BEATS response cycles.

## Configuration
- SYSBUS_ARB_TIMEOUT_EN defined:
  - 10-bit watchdog counts cycles in WAIT and RESP, cleared on each accepted beat.
  - At 1023: pulse tag_err, return to IDLE, owner gets no rs_last.
- SYSBUS_ARB_TIMEOUT_EN undefined: no counter, WAIT is unbounded.

## Structure
- Shared package sysbus_pkg holds:
  - typedef arb_state_t enum {IDLE, ADDR, WDATA, WAIT, RESP}
  - constants TAG_WRITE_BIT = TAG_WIDTH-1, TAG_OWNER_BIT = 0
  - function make_tag(write, owner)
- One sub-module: rr_arbiter2 (2-way round-robin picker, registered pointer).

## Test plan
- Read on port 0 alone, reqack on first ADDR cycle, 8 beats 0x10..0x17 → rs_valid[0] 8 cycles, rs_last on 0x17, reqtag=0x0000.
- Both ports request a read in the same cycle after reset → port 0 granted first, then port 1. reqtag 0x0000 then 0x0001.
- Write on port 1 with reqack delayed 3 cycles per beat → reqtag=0x1001; 8 rq_wnext[1] pulses; req stable while unacked.
- Response with resptag=0x0001 while port 0 owns → respack=1, tag_err pulse, rs_valid=0, state stays WAIT.
- reset asserted mid-RESP at beat 4 → next cycle all outputs 0, IDLE; a new read on port 1 proceeds normally.
- With SYSBUS_ARB_TIMEOUT_EN: read issued, no respcyc for 1023 cycles → tag_err pulse, IDLE, next request granted.
